// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with its memory sequencer.
// Stalls the core while a block refill or word write-through is outstanding.
module dcache_wt_ctrl #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_miss,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [127:0]      mem_block,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  // state  | meaning
  // IDLE   | serving read hits, accepting new requests
  // REFILL | block read outstanding, mem_miss asserted
  // WRITE  | word write-through outstanding, mem_we asserted

  localparam int NUM_LINES = 1 << IDX_W;
  localparam int TAG_W     = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [127:0]         line_q [NUM_LINES];

  logic [1:0]       cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] ref_idx;
  logic [TAG_W-1:0] ref_tag;
  logic             hit;
  logic             rd_hit;
  logic             rd_miss;
  logic             wr_start;
  logic             refill_done;

  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[IDX_W+1:2];
  assign cpu_tag = cpu_addr[ADDR_W-1:IDX_W+2];
  // The refill lands where the request was latched, not where cpu_addr points now.
  assign ref_idx = mem_addr[IDX_W+1:2];
  assign ref_tag = mem_addr[ADDR_W-1:IDX_W+2];
  assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  assign mem_miss = (state_q == S_REFILL);
  assign mem_we   = (state_q == S_WRITE);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    cpu_rdata   = '0;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    wr_start    = 1'b0;
    refill_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_wr) begin
          wr_start = 1'b1;
          stall    = 1'b1;
          state_d  = S_WRITE;
        end else if (cpu_rd) begin
          if (hit) begin
            rd_hit    = 1'b1;
            cpu_rdata = line_q[cpu_idx][{cpu_off, 5'd0} +: 32];
          end else begin
            rd_miss = 1'b1;
            stall   = 1'b1;
            state_d = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        if (mem_ready) begin
          refill_done = 1'b1;
          cpu_rdata   = mem_block[{cpu_off, 5'd0} +: 32];
          state_d     = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      S_WRITE: begin
        if (mem_ready) state_d = S_IDLE;
        else           stall   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (wr_start) begin
        mem_addr <= cpu_addr;
        mem_wd   <= cpu_wdata;
      end
      if (rd_miss) mem_addr <= {cpu_tag, cpu_idx, 2'b00};
      if (refill_done) valid_q[ref_idx] <= 1'b1;
      if (rd_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (rd_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  // Tags and data are not cleared by reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (wr_start && hit) line_q[cpu_idx][{cpu_off, 5'd0} +: 32] <= cpu_wdata;
      if (refill_done) begin
        line_q[ref_idx] <= mem_block;
        tag_q[ref_idx]  <= ref_tag;
      end
    end
  end

endmodule
